sketch_hot_filter: RTL and testbench

- Sits directly downstream of the count-min sketch stage and consumes its per-hash count vector and address.
- Takes the minimum across the hash rows as the count-min estimate and compares it against a programmable hot threshold.
- Queues hot addresses with their estimate in a small FIFO that feeds the migration/hot-page consumer through a valid/ready interface.
- The sketch cannot be back-pressured, so the block drops entries when the FIFO is full and counts every drop.

---
 rtl/sketch_hot_filter_if.sv | 13 +
 rtl/sketch_hot_filter.sv | 137 +++++++++++++
 tb/tb_sketch_hot_filter.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/sketch_hot_filter_if.sv
// Hot-entry output bus between sketch_hot_filter and the migration/hot-page consumer.
interface sketch_hot_filter_if #(
    parameter int ADDR_SIZE = 22,
    parameter int CNT_SIZE  = 32
);
    logic                 hot_valid;
    logic                 hot_ready;
    logic [ADDR_SIZE-1:0] hot_addr;
    logic [CNT_SIZE-1:0]  hot_cnt;

    modport master (output hot_valid, hot_addr, hot_cnt, input hot_ready);
    modport slave  (input hot_valid, hot_addr, hot_cnt, output hot_ready);
endinterface

// File: rtl/sketch_hot_filter.sv
// Count-min hot filter: min across hash rows, threshold compare, hot FIFO with drop counting.
// Optional recent-address dedup filter enabled by defining SKETCH_HOT_DEDUP_EN.
module sketch_hot_filter #(
    parameter int NUM_HASH      = 4,
    parameter int ADDR_SIZE     = 22,
    parameter int CNT_SIZE      = 32,
    parameter int FIFO_DEPTH    = 8,
    parameter int RECENT_DEPTH  = 4,
    parameter int DROP_CNT_SIZE = 16
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               in_valid,
    input  logic [ADDR_SIZE-1:0]               in_addr,
    input  logic [NUM_HASH-1:0][CNT_SIZE-1:0]  in_cnt_array,
    input  logic [CNT_SIZE-1:0]                hot_threshold,
    sketch_hot_filter_if.master                hot,
    output logic [$clog2(FIFO_DEPTH):0]        fifo_level,
    output logic [DROP_CNT_SIZE-1:0]           drop_cnt
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int LW = PW + 1;

    if (NUM_HASH < 1 || RECENT_DEPTH < 1 || FIFO_DEPTH < 2 ||
        (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_params
        $error("sketch_hot_filter: illegal parameter combination");
    end

    logic                 s1_valid;
    logic [ADDR_SIZE-1:0] s1_addr;
    logic [CNT_SIZE-1:0]  s1_min;
    logic [CNT_SIZE-1:0]  in_min;

    logic [ADDR_SIZE-1:0] mem_addr [FIFO_DEPTH];
    logic [CNT_SIZE-1:0]  mem_cnt  [FIFO_DEPTH];
    logic [PW-1:0]        rd_ptr, wr_ptr, next_rd;
    logic [ADDR_SIZE-1:0] head_addr, head_addr_nxt;
    logic [CNT_SIZE-1:0]  head_cnt, head_cnt_nxt;
    logic [LW-1:0]        level_nxt;

    logic cand, hit, pop, push, drop, has_room;

    always_comb begin
        in_min = in_cnt_array[0];
        for (int i = 1; i < NUM_HASH; i++)
            if (in_cnt_array[i] < in_min) in_min = in_cnt_array[i];
    end

    assign cand     = s1_valid && (hot_threshold != '0) && (s1_min >= hot_threshold);
    assign pop      = (fifo_level != '0) && hot.hot_ready;
    assign has_room = fifo_level != LW'(FIFO_DEPTH);
    assign push     = cand && !hit && (has_room || pop);
    assign drop     = cand && !hit && !push;

    assign next_rd   = rd_ptr + PW'(pop);
    assign level_nxt = fifo_level + LW'(push) - LW'(pop);

    // The head registers look through the FIFO when the new head is the entry being written now.
    always_comb begin
        head_addr_nxt = head_addr;
        head_cnt_nxt  = head_cnt;
        if (level_nxt != '0) begin
            if (push && next_rd == wr_ptr) begin
                head_addr_nxt = s1_addr;
                head_cnt_nxt  = s1_min;
            end else begin
                head_addr_nxt = mem_addr[next_rd];
                head_cnt_nxt  = mem_cnt[next_rd];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_addr[wr_ptr] <= s1_addr;
            mem_cnt[wr_ptr]  <= s1_min;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid   <= 1'b0;
            s1_addr    <= '0;
            s1_min     <= '0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            fifo_level <= '0;
            head_addr  <= '0;
            head_cnt   <= '0;
            drop_cnt   <= '0;
        end else begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_addr <= in_addr;
                s1_min  <= in_min;
            end
            if (push) wr_ptr <= wr_ptr + 1'b1;
            rd_ptr     <= next_rd;
            fifo_level <= level_nxt;
            head_addr  <= head_addr_nxt;
            head_cnt   <= head_cnt_nxt;
            if (drop && drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;
        end
    end

`ifdef SKETCH_HOT_DEDUP_EN
    localparam int RW = (RECENT_DEPTH > 1) ? $clog2(RECENT_DEPTH) : 1;

    logic [ADDR_SIZE-1:0]    recent_addr [RECENT_DEPTH];
    logic [RECENT_DEPTH-1:0] recent_vld;
    logic [RW-1:0]           rr_ptr;

    // Match uses pre-edge contents; an insert this cycle is not visible until the next.
    always_comb begin
        hit = 1'b0;
        for (int i = 0; i < RECENT_DEPTH; i++)
            if (recent_vld[i] && recent_addr[i] == s1_addr) hit = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            recent_vld <= '0;
            rr_ptr     <= '0;
        end else if (push) begin
            recent_addr[rr_ptr] <= s1_addr;
            recent_vld[rr_ptr]  <= 1'b1;
            rr_ptr <= (rr_ptr == RW'(RECENT_DEPTH - 1)) ? '0 : rr_ptr + 1'b1;
        end
    end
`else
    assign hit = 1'b0;
`endif

    assign hot.hot_valid = fifo_level != '0;
    assign hot.hot_addr  = head_addr;
    assign hot.hot_cnt   = head_cnt;
endmodule

// File: tb/tb_sketch_hot_filter.sv
// Directed bench for sketch_hot_filter: threshold, FIFO order/full/drop, reset flush, dedup.
module tb_sketch_hot_filter;
    localparam int NH = 4, AW = 22, CW = 32, FD = 8, DW = 16;

    logic                     clk = 1'b0;
    logic                     rst;
    logic                     in_valid;
    logic [AW-1:0]            in_addr;
    logic [NH-1:0][CW-1:0]    in_cnt_array;
    logic [CW-1:0]            hot_threshold;
    logic [$clog2(FD):0]      fifo_level;
    logic [DW-1:0]            drop_cnt;

    int n_tests = 0;
    int n_fail  = 0;
    int n_out   = 0;
    bit mon     = 1'b0;
    bit seen;

    sketch_hot_filter_if #(.ADDR_SIZE(AW), .CNT_SIZE(CW)) hot_bus ();

    sketch_hot_filter #(
        .NUM_HASH(NH), .ADDR_SIZE(AW), .CNT_SIZE(CW), .FIFO_DEPTH(FD),
        .RECENT_DEPTH(4), .DROP_CNT_SIZE(DW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_addr       (in_addr),
        .in_cnt_array  (in_cnt_array),
        .hot_threshold (hot_threshold),
        .hot           (hot_bus.master),
        .fifo_level    (fifo_level),
        .drop_cnt      (drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        if (mon && hot_bus.hot_valid && hot_bus.hot_ready) n_out++;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [AW-1:0] a,
                         input int c0, input int c1, input int c2, input int c3);
        in_valid        = v;
        in_addr         = a;
        in_cnt_array[0] = CW'(c0);
        in_cnt_array[1] = CW'(c1);
        in_cnt_array[2] = CW'(c2);
        in_cnt_array[3] = CW'(c3);
    endtask

    task automatic idle();
        drive(1'b0, '0, 0, 0, 0, 0);
    endtask

    initial begin
        rst = 1'b1;
        hot_threshold = 5;
        hot_bus.hot_ready = 1'b0;
        idle();
        tick(); tick();
        rst = 1'b0;
        chk("rst_valid", hot_bus.hot_valid, 0);
        chk("rst_level", fifo_level, 0);
        chk("rst_drop",  drop_cnt, 0);
        chk("rst_addr",  hot_bus.hot_addr, 0);
        chk("rst_cnt",   hot_bus.hot_cnt, 0);

        // basic hot entry, 2-edge latency
        drive(1'b1, 22'h12345, 7, 6, 9, 8);
        tick();
        idle();
        chk("lat_e0_valid", hot_bus.hot_valid, 0);
        tick();
        chk("basic_valid", hot_bus.hot_valid, 1);
        chk("basic_addr",  hot_bus.hot_addr, 22'h12345);
        chk("basic_cnt",   hot_bus.hot_cnt, 6);
        chk("basic_level", fifo_level, 1);
        hot_bus.hot_ready = 1'b1;
        tick();
        hot_bus.hot_ready = 1'b0;
        chk("empty_valid", hot_bus.hot_valid, 0);
        chk("empty_hold",  hot_bus.hot_addr, 22'h12345);

        // below threshold, then detection disabled
        drive(1'b1, 22'h1, 7, 4, 9, 8);
        tick();
        hot_threshold = 0;
        drive(1'b1, 22'h2, 9, 9, 9, 9);
        tick();
        idle();
        tick(); tick();
        hot_threshold = 5;
        chk("cold_valid", hot_bus.hot_valid, 0);
        chk("cold_level", fifo_level, 0);
        chk("cold_drop",  drop_cnt, 0);

        // overflow: 10 back-to-back hot entries into an 8-deep FIFO
        for (int i = 1; i <= 10; i++) begin
            drive(1'b1, AW'(i), i + 20, 5 + i, 99, 99);
            tick();
        end
        idle();
        tick(); tick();
        chk("ovf_level", fifo_level, 8);
        chk("ovf_drop",  drop_cnt, 2);
        hot_bus.hot_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            chk($sformatf("ovf_valid%0d", i), hot_bus.hot_valid, 1);
            chk($sformatf("ovf_addr%0d", i),  hot_bus.hot_addr, i);
            chk($sformatf("ovf_cnt%0d", i),   hot_bus.hot_cnt, 5 + i);
            tick();
        end
        hot_bus.hot_ready = 1'b0;
        chk("ovf_drained", fifo_level, 0);

        // fill to full with min == threshold, then pop and push together
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, AW'(32'h100 + i), 5, 6, 7, 8);
            tick();
        end
        idle();
        tick(); tick();
        chk("full_level", fifo_level, 8);
        chk("full_eq_cnt", hot_bus.hot_cnt, 5);
        drive(1'b1, 22'h200, 9, 9, 9, 9);
        tick();
        idle();
        hot_bus.hot_ready = 1'b1;
        tick();
        hot_bus.hot_ready = 1'b0;
        chk("fullpp_level", fifo_level, 8);
        chk("fullpp_drop",  drop_cnt, 2);
        chk("fullpp_head",  hot_bus.hot_addr, 22'h101);
        hot_bus.hot_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("fullpp_addr%0d", i), hot_bus.hot_addr,
                (i < 7) ? 64'h101 + 64'(i) : 64'h200);
            tick();
        end
        hot_bus.hot_ready = 1'b0;
        chk("fullpp_drained", fifo_level, 0);

        // reset with 3 queued and 1 in flight
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, AW'(32'h300 + i), 9, 9, 9, 9);
            tick();
        end
        idle();
        chk("pre_rst_level", fifo_level, 3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_valid", hot_bus.hot_valid, 0);
        chk("midrst_level", fifo_level, 0);
        chk("midrst_drop",  drop_cnt, 0);
        hot_bus.hot_ready = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (hot_bus.hot_valid) seen = 1'b1;
        end
        chk("midrst_nothing", seen, 0);

        // same address twice, 3 cycles apart
        mon = 1'b1;
        drive(1'b1, 22'h40, 8, 8, 8, 8);
        tick();
        idle();
        tick(); tick();
        drive(1'b1, 22'h40, 8, 8, 8, 8);
        tick();
        idle();
        for (int i = 0; i < 6; i++) tick();
        mon = 1'b0;
`ifdef SKETCH_HOT_DEDUP_EN
        chk("dedup_outputs", n_out, 1);
`else
        chk("dedup_outputs", n_out, 2);
`endif
        chk("dedup_drop", drop_cnt, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
